// File: rtl/number_pkg.sv
// number_pkg -- shared types and constants for the number_entry keypad block.
//   state_t   : entry FSM states (ARMED, HELD, COMMIT)
//   bcd_t     : one BCD digit, 4 bits
//   KEY_COUNT : number of decimal key lines (10)
package number_pkg;

   localparam int KEY_COUNT = 10;

   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {
      ARMED  = 2'd0,   // waiting for a fresh key press
      HELD   = 2'd1,   // key seen, waiting for all keys released
      COMMIT = 2'd2    // entry presented on out_valid, waiting for out_ready
   } state_t;

endpackage

// File: rtl/key_decoder.sv
// key_decoder -- turns the one-hot key lines into {valid, bcd}.
//   inp   : level key lines, bit k = decimal key k held
//   valid : exactly one key line is set
//   bcd   : index of the set line (meaningful only when valid)
module key_decoder
   import number_pkg::*;
(
   input  logic [KEY_COUNT-1:0] inp,
   output logic                 valid,
   output bcd_t                 bcd
);

   logic [3:0] ones;

   always_comb begin
      ones = '0;
      bcd  = '0;
      for (int k = 0; k < KEY_COUNT; k++) begin
         if (inp[k]) begin
            ones = ones + 4'd1;
            bcd  = bcd_t'(k);
         end
      end
      // Zero or multi-hot input is never a key press.
      valid = (ones == 4'd1);
   end

endmodule

// File: rtl/number_entry.sv
// number_entry -- keypad number entry: collects BCD digits from one-hot key
// lines, supports clear/backspace, and hands the entry off via out_valid /
// out_ready.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous, active-low reset
//   inp[9:0]   : level key lines, one-hot
//   clr        : clear entry (highest priority)
//   bksp       : delete most recent digit
//   commit     : present the current entry
//   out_ready  : consumer accepts the presented entry
//   digits     : packed BCD, newest digit in [3:0], unused digits zero
//   count      : number of stored digits
//   digit_stb  : one-cycle pulse after a digit is stored
//   full       : count == MAX_DIGITS
//   out_valid  : entry presented on digits/count
//   fsm_state  : current FSM state for observation
//
// Handshake: out_valid rises the cycle after commit is sampled and holds,
// with digits/count frozen, until a rising edge sees out_valid && out_ready;
// that edge clears the entry and drops out_valid.
//
// Optional feature: define NUMBER_ENTRY_DEBOUNCE_EN to require
// DEBOUNCE_CYCLES stable cycles before a press or a release is recognised.
module number_entry
   import number_pkg::*;
#(
   parameter int MAX_DIGITS      = 4,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [KEY_COUNT-1:0]             inp,
   input  logic                             clr,
   input  logic                             bksp,
   input  logic                             commit,
   input  logic                             out_ready,
   output logic [4*MAX_DIGITS-1:0]          digits,
   output logic [$clog2(MAX_DIGITS+1)-1:0]  count,
   output logic                             digit_stb,
   output logic                             full,
   output logic                             out_valid,
   output state_t                           fsm_state
);

   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

   if (MAX_DIGITS < 1 || MAX_DIGITS > 8) begin : g_bad_max_digits
      $error("number_entry: MAX_DIGITS must be in 1..8");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("number_entry: DEBOUNCE_CYCLES must be at least 1");
   end

   state_t state;
   logic   key_valid;
   bcd_t   key_bcd;
   logic   any_key;
   logic   press;     // a recognised single-key press this cycle
   logic   released;  // all keys recognised as released this cycle
   logic [4*MAX_DIGITS-1:0] digits_shl;

   key_decoder u_dec (
      .inp   (inp),
      .valid (key_valid),
      .bcd   (key_bcd)
   );

   assign any_key   = (inp != '0);
   assign fsm_state = state;

   // Left shift with the new digit in the bottom nibble; written this way so
   // MAX_DIGITS=1 needs no degenerate part-select.
   always_comb begin
      digits_shl      = digits << 4;
      digits_shl[3:0] = key_bcd;
   end

`ifdef NUMBER_ENTRY_DEBOUNCE_EN
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES);

   logic [DW-1:0]        db_cnt;
   logic [DW-1:0]        db_cnt_nx;
   logic [KEY_COUNT-1:0] db_last;
   logic                 same;

   // db_cnt counts consecutive identical samples of inp, saturating.
   assign same      = (inp == db_last);
   assign db_cnt_nx = !same ? DW'(1) : ((db_cnt == DB_MAX) ? db_cnt : db_cnt + DW'(1));
   // A press needs DEBOUNCE_CYCLES prior stable samples plus the current one,
   // giving a strobe DEBOUNCE_CYCLES+1 edges after the key first appears.
   assign press     = key_valid && same && (db_cnt == DB_MAX);
   assign released  = !any_key && (db_cnt_nx == DB_MAX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         db_cnt  <= '0;
         db_last <= '0;
      end else begin
         db_cnt  <= db_cnt_nx;
         db_last <= inp;
      end
   end
`else
   assign press    = key_valid;
   assign released = !any_key;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ARMED;
         digits    <= '0;
         count     <= '0;
         digit_stb <= 1'b0;
         full      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         digit_stb <= 1'b0;
         if (clr) begin
            digits    <= '0;
            count     <= '0;
            full      <= 1'b0;
            out_valid <= 1'b0;
            state     <= any_key ? HELD : ARMED;
         end else begin
            case (state)
               ARMED, HELD: begin
                  if (commit) begin
                     state     <= COMMIT;
                     out_valid <= 1'b1;
                  end else if (bksp) begin
                     if (count != '0) begin
                        digits <= digits >> 4;
                        count  <= count - CW'(1);
                        full   <= 1'b0;
                     end
                  end else if (state == ARMED) begin
                     if (press) begin
                        state <= HELD;
                        // Leading zero and overflow presses are swallowed.
                        if (!(key_bcd == 4'd0 && count == '0) && !full) begin
                           digits    <= digits_shl;
                           count     <= count + CW'(1);
                           full      <= (count == MAX_CNT - CW'(1));
                           digit_stb <= 1'b1;
                        end
                     end
                  end else if (released) begin
                     state <= ARMED;
                  end
               end
               COMMIT: begin
                  if (out_ready) begin
                     digits    <= '0;
                     count     <= '0;
                     full      <= 1'b0;
                     out_valid <= 1'b0;
                     state     <= any_key ? HELD : ARMED;
                  end
               end
               default: state <= ARMED;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_number_entry.sv
// tb_number_entry -- self-checking bench for number_entry (MAX_DIGITS=4).
module tb_number_entry;
   import number_pkg::*;

   localparam int MAXD = 4;
   localparam int DB   = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  inp;
   logic        clr, bksp, commit, out_ready;
   logic [15:0] digits;
   logic [2:0]  count;
   logic        digit_stb, full, out_valid;
   state_t      fsm_state;

   int errors = 0;
   int checks = 0;

   number_entry #(.MAX_DIGITS(MAXD), .DEBOUNCE_CYCLES(DB)) dut (
      .clk       (clk),
      .reset     (reset),
      .inp       (inp),
      .clr       (clr),
      .bksp      (bksp),
      .commit    (commit),
      .out_ready (out_ready),
      .digits    (digits),
      .count     (count),
      .digit_stb (digit_stb),
      .full      (full),
      .out_valid (out_valid),
      .fsm_state (fsm_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   wire [21:0] obs = {digits, count, digit_stb, full, out_valid};

   // ---------------- reference model ----------------
   // The entry is a queue of digits, oldest first. Two flags describe the
   // keypad: waiting for release, and presenting a committed entry.
   logic [3:0] exp_q[$];
   bit m_wait, m_present, m_stb;

   task automatic model_reset();
      exp_q.delete();
      m_wait    = 0;
      m_present = 0;
      m_stb     = 0;
   endtask

   task automatic model_step(input logic [9:0] i, input logic c, input logic b,
                             input logic cm, input logic r);
      m_stb = 0;
      if (c) begin
         exp_q.delete(); m_present = 0; m_wait = (i != 0);
      end else if (m_present) begin
         if (r) begin exp_q.delete(); m_present = 0; m_wait = (i != 0); end
      end else if (cm) begin
         m_present = 1;
      end else if (b) begin
         if (exp_q.size() > 0) void'(exp_q.pop_back());
      end else if (!m_wait) begin
         if ($countones(i) == 1) begin
            m_wait = 1;
            if (!(i[0] && exp_q.size() == 0) && exp_q.size() < MAXD) begin
               exp_q.push_back(4'($clog2(i)));
               m_stb = 1;
            end
         end
      end else if (i == 0) begin
         m_wait = 0;
      end
   endtask

   function automatic logic [21:0] exp_vec();
      int v = 0;
      foreach (exp_q[j]) v = v * 16 + int'(exp_q[j]);
      return {16'(v), 3'(exp_q.size()), m_stb, (exp_q.size() == MAXD), m_present};
   endfunction

   // ---------------- driver ----------------
   task automatic drive_cycle(input logic [9:0] i, input logic c, input logic b,
                              input logic cm, input logic r);
      @(negedge clk);
      inp = i; clr = c; bksp = b; commit = cm; out_ready = r;
      @(posedge clk);
      model_step(i, c, b, cm, r);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0; inp = '0; clr = 0; bksp = 0; commit = 0; out_ready = 0;
      model_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (obs !== 22'd0) begin
         errors++; $display("FAIL reset_state: got %h want %h", obs, 22'd0);
      end
      reset = 1'b1;
   endtask

   task automatic test_sequence();
      logic [9:0] keys[6] = '{10'h002, 10'h000, 10'h004, 10'h000, 10'h008, 10'h000};
      int stb_n = 0;
      drive_cycle('0, 1, 0, 0, 0);
      for (int s = 0; s < 6; s++) begin
         for (int n = 0; n < 2; n++) begin
            drive_cycle(keys[s], 0, 0, 0, 0);
            stb_n += int'(digit_stb);
            checks++;
            if (obs !== exp_vec()) begin
               errors++; $display("FAIL sequence s%0d: got %h want %h", s, obs, exp_vec());
            end
         end
      end
      checks++;
      if (digits !== 16'h0123 || count !== 3'd3 || stb_n != 3) begin
         errors++;
         $display("FAIL sequence_final: got digits=%h count=%0d stb=%0d want 0123/3/3",
                  digits, count, stb_n);
      end
   endtask

   task automatic test_hold_and_zero();
      int stb_n = 0;
      drive_cycle('0, 1, 0, 0, 0);
      for (int n = 0; n < 10; n++) begin
         drive_cycle(10'h020, 0, 0, 0, 0);
         stb_n += int'(digit_stb);
      end
      drive_cycle('0, 0, 0, 0, 0);
      checks++;
      if (stb_n != 1 || digits !== 16'h0005 || obs !== exp_vec()) begin
         errors++; $display("FAIL hold_key: got stb=%0d digits=%h want 1/0005", stb_n, digits);
      end
      drive_cycle('0, 1, 0, 0, 0);
      drive_cycle(10'h001, 0, 0, 0, 0);
      drive_cycle('0, 0, 0, 0, 0);
      checks++;
      if (count !== 3'd0 || digit_stb !== 1'b0 || obs !== exp_vec()) begin
         errors++; $display("FAIL leading_zero: got count=%0d want 0", count);
      end
   endtask

   task automatic test_overflow();
      int stb_n = 0;
      drive_cycle('0, 1, 0, 0, 0);
      for (int k = 9; k >= 5; k--) begin
         drive_cycle(10'(1 << k), 0, 0, 0, 0);
         if (k == 5) stb_n += int'(digit_stb);
         drive_cycle('0, 0, 0, 0, 0);
      end
      checks++;
      if (digits !== 16'h9876 || full !== 1'b1 || stb_n != 0 || obs !== exp_vec()) begin
         errors++;
         $display("FAIL overflow: got digits=%h full=%b stb5=%0d want 9876/1/0", digits, full, stb_n);
      end
      drive_cycle('0, 0, 1, 0, 0);
      checks++;
      if (digits !== 16'h0987 || count !== 3'd3 || full !== 1'b0) begin
         errors++; $display("FAIL bksp: got digits=%h count=%0d want 0987/3", digits, count);
      end
   endtask

   task automatic test_commit_stall();
      drive_cycle('0, 1, 0, 0, 0);
      drive_cycle(10'h010, 0, 0, 0, 0);
      drive_cycle('0, 0, 0, 0, 0);
      drive_cycle(10'h004, 0, 0, 0, 0);
      drive_cycle('0, 0, 0, 0, 0);
      drive_cycle('0, 0, 0, 1, 0);
      for (int n = 0; n < 5; n++) begin
         drive_cycle(10'(1 << $urandom_range(1, 9)), 0, n[0], n[1], 0);
         checks++;
         if (out_valid !== 1'b1 || digits !== 16'h0042 || obs !== exp_vec()) begin
            errors++; $display("FAIL commit_hold n%0d: got %h want %h", n, obs, exp_vec());
         end
      end
      drive_cycle('0, 0, 0, 0, 1);
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || obs !== exp_vec()) begin
         errors++; $display("FAIL commit_accept: got count=%0d valid=%b want 0/0", count, out_valid);
      end
   endtask

   task automatic test_priority();
      drive_cycle('0, 1, 0, 0, 0);
      drive_cycle(10'h040, 0, 0, 0, 0);
      drive_cycle('0, 0, 0, 0, 0);
      drive_cycle(10'h008, 1, 0, 1, 0);
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || obs !== exp_vec()) begin
         errors++; $display("FAIL clr_priority: got count=%0d valid=%b want 0/0", count, out_valid);
      end
      drive_cycle('0, 0, 0, 0, 0);
      drive_cycle(10'h003, 0, 0, 0, 0);
      checks++;
      if (count !== 3'd0 || digit_stb !== 1'b0 || obs !== exp_vec()) begin
         errors++; $display("FAIL multi_hot: got count=%0d stb=%b want 0/0", count, digit_stb);
      end
   endtask

   task automatic test_reset_mid();
      drive_cycle('0, 1, 0, 0, 0);
      drive_cycle(10'h080, 0, 0, 0, 0);
      drive_cycle('0, 0, 0, 0, 0);
      #2 reset = 1'b0;
      #1;
      model_reset();
      checks++;
      if (obs !== 22'd0) begin
         errors++; $display("FAIL reset_mid_entry: got %h want 0", obs);
      end
      @(negedge clk);
      inp = '0; clr = 0; bksp = 0; commit = 0; out_ready = 0;
      reset = 1'b1;
      drive_cycle(10'h002, 0, 0, 0, 0);
      drive_cycle('0, 0, 0, 1, 0);
      drive_cycle('0, 0, 0, 0, 0);
      #2 reset = 1'b0;
      #1;
      model_reset();
      checks++;
      if (obs !== 22'd0) begin
         errors++; $display("FAIL reset_mid_commit: got %h want 0", obs);
      end
      // Key already held when reset releases counts as a fresh press.
      @(negedge clk);
      inp = 10'h010; clr = 0; bksp = 0; commit = 0; out_ready = 0;
      reset = 1'b1;
      @(posedge clk);
      model_step(10'h010, 0, 0, 0, 0);
      #1;
      checks++;
      if (digit_stb !== 1'b1 || digits !== 16'h0004 || obs !== exp_vec()) begin
         errors++; $display("FAIL held_after_reset: got %h want %h", obs, exp_vec());
      end
   endtask

   task automatic test_random();
      logic [9:0] i;
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 19))
            0, 1, 2, 3, 4, 5, 6, 7, 8, 9: i = '0;
            10, 11, 12, 13, 14, 15, 16:   i = 10'(1 << $urandom_range(0, 9));
            default:                      i = 10'($urandom_range(0, 1023));
         endcase
         drive_cycle(i, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 8,
                     $urandom_range(0, 99) < 5, $urandom_range(0, 1) == 1);
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL random n%0d: got %h want %h", n, obs, exp_vec());
         end
      end
   endtask

   task automatic test_glitch();
      int stb_n = 0;
      int stb_at = -1;
      drive_cycle('0, 1, 0, 0, 0);
      for (int n = 0; n < 2; n++) begin
         drive_cycle(10'h080, 0, 0, 0, 0);
         stb_n += int'(digit_stb);
      end
      for (int n = 0; n < 8; n++) begin
         drive_cycle('0, 0, 0, 0, 0);
         stb_n += int'(digit_stb);
      end
      checks++;
      if (stb_n != 0 || count !== 3'd0) begin
         errors++; $display("FAIL glitch: got stb=%0d count=%0d want 0/0", stb_n, count);
      end
      for (int n = 0; n < 8; n++) begin
         drive_cycle(10'h080, 0, 0, 0, 0);
         if (digit_stb && stb_at < 0) stb_at = n;
      end
      checks++;
      if (stb_at != DB) begin
         errors++; $display("FAIL debounce_latency: got %0d want %0d", stb_at, DB);
      end
      for (int n = 0; n < 6; n++) drive_cycle('0, 0, 0, 0, 0);
      checks++;
      if (count !== 3'd1 || digits !== 16'h0007) begin
         errors++; $display("FAIL debounce_digit: got %h/%0d want 0007/1", digits, count);
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
`ifdef NUMBER_ENTRY_DEBOUNCE_EN
      test_glitch();
`else
      test_sequence();
      test_hold_and_zero();
      test_overflow();
      test_commit_stall();
      test_priority();
      test_reset_mid();
      test_random();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/number_entry.md
NUMBER_ENTRY -- requirements
Module: number_entry

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 4, meaning the maximum number of stored BCD digits (legal range 1..8).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of cycles a key must be stable (used only with the REQ-030 macro).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port inp, input, 10 bits: level key lines, one-hot; bit k set means decimal key k is held.
REQ-006 SHALL have port clr, input, 1 bit: clear the entry (synchronous, single-cycle pulse).
REQ-007 SHALL have port bksp, input, 1 bit: delete the most recent digit.
REQ-008 SHALL have port commit, input, 1 bit: request hand-off of the current entry.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the committed entry.
REQ-010 SHALL have port digits, output, 4*MAX_DIGITS bits: packed BCD, least-significant digit in [3:0], unused digits zero.
REQ-011 SHALL have port count, output, $clog2(MAX_DIGITS+1) bits: number of digits stored.
REQ-012 SHALL have port digit_stb, output, 1 bit: one-cycle pulse when a digit is accepted.
REQ-013 SHALL have port full, output, 1 bit: asserted when count==MAX_DIGITS.
REQ-014 SHALL have port out_valid, output, 1 bit: a committed entry is presented on digits/count.

Function
REQ-015 SHALL run FSM states ARMED (wait for press), HELD (wait for all-zero inp), and COMMIT (out_valid high).
REQ-016 In ARMED, a cycle with exactly one inp bit set SHALL accept that digit and go to HELD; all-zero or multi-hot inp SHALL do nothing.
REQ-017 In HELD, the FSM SHALL return to ARMED only after inp==0 for one cycle; holding a key never repeats it.
REQ-018 An accepted digit SHALL shift digits left by 4 bits, insert the new BCD in [3:0], increment count, and pulse digit_stb in the next cycle (latency 1).
REQ-019 Leading-zero rule: key 0 with count==0 SHALL enter HELD without storing or pulsing.
REQ-020 Overflow: a key press while full SHALL enter HELD with digits/count unchanged and no digit_stb.
REQ-021 bksp with count>0 SHALL shift digits right by 4 bits, zero the top digit, and decrement count; with count==0 it SHALL be ignored.
REQ-022 commit in ARMED or HELD SHALL move to COMMIT and raise out_valid next cycle; commit with count==0 is legal and presents value 0.
REQ-023 In COMMIT, digits/count SHALL be frozen and inp, bksp, and commit ignored until out_valid && out_ready.
REQ-024 On the out_valid && out_ready handshake, the block SHALL clear digits/count and go to HELD if inp!=0, else ARMED.
REQ-025 Same-cycle priority SHALL be clr > commit > bksp > key press; lower-priority events in that cycle are dropped.
REQ-026 clr in any state SHALL zero digits/count, drop out_valid, and go to HELD if inp!=0, else ARMED.

Reset
REQ-027 Asserting reset (low) SHALL immediately force state ARMED, digits=0, count=0, digit_stb=0, full=0, out_valid=0, and debounce counter=0.
REQ-028 Reset mid-COMMIT SHALL discard the entry without any handshake.
REQ-029 After release, the first rising edge SHALL see a key already held as a new press.

Configuration
REQ-030 Macro NUMBER_ENTRY_DEBOUNCE_EN defined: inp SHALL be stable and one-hot for DEBOUNCE_CYCLES consecutive cycles before acceptance, raising digit_stb latency to DEBOUNCE_CYCLES+1.
REQ-031 Release detection SHALL likewise require DEBOUNCE_CYCLES cycles of zero inp.
REQ-032 Macro NUMBER_ENTRY_DEBOUNCE_EN undefined: no counter SHALL exist and REQ-016..018 timing applies unchanged.

Structure
REQ-033 Shared package number_pkg SHALL hold the FSM state enum, the BCD digit typedef (4 bits), and the KEY_COUNT=10 constant.
REQ-034 One sub-module, key_decoder, SHALL convert one-hot inp to {valid, bcd}, with valid=0 for zero or multi-hot input.

Verification
REQ-035 Press 1, release, press 2, release, press 3, release -> digits=0x0123, count=3, three digit_stb pulses.
REQ-036 Hold key 5 for 10 cycles -> exactly one digit_stb; key 0 first on empty entry -> count stays 0.
REQ-037 MAX_DIGITS=4, enter 9,8,7,6,5 -> digits=0x9876, full=1, fifth press gives no strobe; bksp -> 0x0987, count=3.
REQ-038 commit with out_ready=0 for 5 cycles while keys pressed -> out_valid held, digits frozen; out_ready=1 -> count=0 next cycle.
REQ-039 clr, commit, and key press in the same cycle -> entry cleared, out_valid=0; inp=0x003 -> ignored.
REQ-040 Reset asserted mid-entry and mid-COMMIT -> all outputs 0 immediately; with the debounce macro, a 2-cycle glitch -> no strobe.
